// File: rtl/mem_writeback.sv
// -----------------------------------------------------------------------------
// mem_writeback
//
// Stage that follows execute. It issues data-memory reads, aligns and extends
// the returning load data, forms set-on-compare and upper-immediate results,
// and drives the register-file write port. It also resolves branches, emits a
// one-cycle fetch redirect and squashes the instructions in the branch shadow.
// Every instruction takes exactly DM_LATENCY+1 cycles from input to writeback.
// The stage never stalls.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous reset, active low
//   p_i              execute result {P[47], P[35:0]}
//   regwrite_i       write result to the register file
//   regwriteui_i     upper-immediate write
//   sr_i             set-on-compare write
//   regfile_addr_i   destination register
//   dm_re_i          load
//   cmpsel_i         compare flag source (0 signed, 1 unsigned)
//   loadtype_i       load size / sign
//   branchen_i       branch instruction
//   branchtype_i     branch condition
//   branchtarget_i   branch target PC
//   dm_rdata_i       data-memory read word
//   dm_re_o          data-memory read enable
//   dm_addr_o        data-memory word address
//   wb_en_o          register-file write enable
//   wb_addr_o        register-file write address
//   wb_data_o        register-file write data
//   branch_taken_o   one-cycle redirect pulse
//   branch_target_o  redirect PC
// -----------------------------------------------------------------------------
module mem_writeback #(
  parameter int DM_ADDR_WIDTH  = 10,
  parameter int DM_LATENCY     = 2,
  parameter int BRANCH_SHADOW  = 2,
  parameter int REG_ADDR_WIDTH = 5,
  localparam int DATA_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [36:0]               p_i,
  input  logic                      regwrite_i,
  input  logic                      regwriteui_i,
  input  logic                      sr_i,
  input  logic [REG_ADDR_WIDTH-1:0] regfile_addr_i,
  input  logic                      dm_re_i,
  input  logic                      cmpsel_i,
  input  logic [2:0]                loadtype_i,
  input  logic                      branchen_i,
  input  logic [2:0]                branchtype_i,
  input  logic [15:0]               branchtarget_i,
  input  logic [31:0]               dm_rdata_i,
  output logic                      dm_re_o,
  output logic [DM_ADDR_WIDTH-1:0]  dm_addr_o,
  output logic                      wb_en_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  output logic                      branch_taken_o,
  output logic [15:0]               branch_target_o
);

  localparam int SQ_W = (BRANCH_SHADOW < 1) ? 1 : $clog2(BRANCH_SHADOW + 1);

  // One in-flight instruction. The non-load result is formed at issue so only
  // the load path has to wait for the memory word.
  typedef struct packed {
    logic                      wen;
    logic                      ld;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [1:0]                off;
    logic [2:0]                ltype;
    logic [31:0]               alu;
  } entry_t;

  entry_t                    pipe_q [DM_LATENCY];
  entry_t                    entry_d;
  entry_t                    last;
  logic [SQ_W-1:0]           sq_cnt_q, sq_cnt_d;
  logic                      wb_en_q, wb_en_d;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic                      br_taken_q, br_taken_d;
  logic [15:0]               br_target_q, br_target_d;

  logic squash;
  logic zero;
  logic neg;
  logic cond;
  logic taken;
  logic rw_eff;
  logic re_eff;
  logic br_eff;

  // P[35:33] carry no meaning for this stage.
  logic unused_p;
  assign unused_p = ^p_i[35:33];

  // Little-endian lane select and extension of the returned memory word.
  // Halfwords use offset[1]; bytes use the full two-bit offset.
  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  ltype);
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half   = off[1] ? word[31:16] : word[15:0];
    byte_v = word[{off, 3'b000} +: 8];
    case (ltype)
      3'b001:  res = {{16{half[15]}}, half};
      3'b010:  res = {16'h0000, half};
      3'b011:  res = {{24{byte_v[7]}}, byte_v};
      3'b100:  res = {24'h000000, byte_v};
      default: res = word;
    endcase
    return res;
  endfunction

  always_comb begin
    squash = (sq_cnt_q != '0);
    rw_eff = regwrite_i & ~squash;
    re_eff = dm_re_i & ~squash;
    br_eff = branchen_i & ~squash;

    zero = (p_i[31:0] == 32'd0);
    neg  = cmpsel_i ? ~p_i[32] : p_i[36];

    case (branchtype_i)
      3'b000:  cond = zero;
      3'b001:  cond = ~zero;
      3'b010:  cond = neg;
      3'b011:  cond = ~neg;
      3'b100:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
    taken = br_eff & cond;

    entry_d       = '0;
    entry_d.wen   = rw_eff;
    entry_d.ld    = re_eff;
    entry_d.addr  = regfile_addr_i;
    entry_d.off   = p_i[1:0];
    entry_d.ltype = loadtype_i;
    if (regwriteui_i)
      entry_d.alu = {p_i[15:0], 16'h0000};
    else if (sr_i)
      entry_d.alu = {31'b0, neg};
    else
      entry_d.alu = p_i[31:0];

    // A branch inside the shadow is already squashed, so it cannot reload.
    if (taken)
      sq_cnt_d = SQ_W'(BRANCH_SHADOW);
    else if (squash)
      sq_cnt_d = sq_cnt_q - SQ_W'(1);
    else
      sq_cnt_d = sq_cnt_q;

    br_taken_d  = taken;
    br_target_d = taken ? branchtarget_i : br_target_q;

    // The oldest entry meets its memory word in this cycle.
    last      = pipe_q[DM_LATENCY-1];
    wb_en_d   = last.wen;
    wb_addr_d = last.addr;
    wb_data_d = last.ld ? align_load(dm_rdata_i, last.off, last.ltype) : last.alu;
  end

  // ---- issue -> memory-latency pipe -> writeback register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DM_LATENCY; k++) pipe_q[k] <= '0;
      sq_cnt_q    <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      pipe_q[0] <= entry_d;
      for (int k = 1; k < DM_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
      sq_cnt_q    <= sq_cnt_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  assign dm_re_o         = re_eff;
  assign dm_addr_o       = p_i[DM_ADDR_WIDTH+1:2];
  assign wb_en_o         = wb_en_q;
  assign wb_addr_o       = wb_addr_q;
  assign wb_data_o       = wb_data_q;
  assign branch_taken_o  = br_taken_q;
  assign branch_target_o = br_target_q;

endmodule

// File: tb/tb_mem_writeback.sv
module tb_mem_writeback;

  localparam int BS = 2;
  localparam int N  = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic [36:0] p_i;
  logic        regwrite_i, regwriteui_i, sr_i, dm_re_i, cmpsel_i, branchen_i;
  logic [4:0]  regfile_addr_i;
  logic [2:0]  loadtype_i, branchtype_i;
  logic [15:0] branchtarget_i;
  logic [31:0] dm_rdata_i;
  logic        dm_re_o, wb_en_o, branch_taken_o;
  logic [9:0]  dm_addr_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic [15:0] branch_target_o;

  always #5 clk = ~clk;

  mem_writeback #(.DM_ADDR_WIDTH(10), .DM_LATENCY(2), .BRANCH_SHADOW(BS), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .p_i(p_i), .regwrite_i(regwrite_i), .regwriteui_i(regwriteui_i),
    .sr_i(sr_i), .regfile_addr_i(regfile_addr_i), .dm_re_i(dm_re_i), .cmpsel_i(cmpsel_i),
    .loadtype_i(loadtype_i), .branchen_i(branchen_i), .branchtype_i(branchtype_i),
    .branchtarget_i(branchtarget_i), .dm_rdata_i(dm_rdata_i), .dm_re_o(dm_re_o),
    .dm_addr_o(dm_addr_o), .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o));

  // Data memory answering two cycles after dm_re_o; garbage when not read.
  logic [31:0] mem [1024];
  logic        re1 = 1'b0, re2 = 1'b0;
  logic [9:0]  a1 = '0, a2 = '0;
  always @(posedge clk) begin
    re1 <= dm_re_o; a1 <= dm_addr_o;
    re2 <= re1;     a2 <= a1;
  end
  assign dm_rdata_i = re2 ? mem[a2] : 32'hDEAD_BEEF;

  typedef struct {
    logic [36:0] p;
    logic        rw, ui, sr, re, cmp, br, rst_n;
    logic [2:0]  lt, bt;
    logic [4:0]  addr;
    logic [15:0] tgt;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int shadow_end = -1;
  logic [15:0] cur_tgt = '0;
  logic        exp_en [N];
  logic        exp_zero [N];
  logic [4:0]  exp_addr [N];
  logic [31:0] exp_data [N];
  logic        bt_exp [N];
  logic [15:0] tgt_exp [N];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic in_t mk(input logic [36:0] p, input logic rw, input logic ui,
                             input logic sr, input logic re, input logic cmp,
                             input logic [2:0] lt, input logic [4:0] addr);
    in_t r;
    r.p = p; r.rw = rw; r.ui = ui; r.sr = sr; r.re = re; r.cmp = cmp;
    r.lt = lt; r.addr = addr; r.br = 1'b0; r.bt = 3'd0; r.tgt = 16'h0; r.rst_n = 1'b1;
    return r;
  endfunction

  function automatic in_t mkbr(input logic [36:0] p, input logic [2:0] bt, input logic [15:0] tgt);
    in_t r;
    r = mk(p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    r.br = 1'b1; r.bt = bt; r.tgt = tgt;
    return r;
  endfunction

  // Load result from plain arithmetic on the memory word.
  function automatic logic [31:0] ld_model(input logic [31:0] w, input int off, input logic [2:0] lt);
    int b, h;
    b = int'((w >> (8 * off)) & 32'hFF);
    h = int'((w >> (16 * (off / 2))) & 32'hFFFF);
    case (lt)
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd2:    return h;
      3'd3:    return (b >= 128) ? b - 256 : b;
      3'd4:    return b;
      default: return w;
    endcase
  endfunction

  // Apply one instruction and check everything observable in this cycle.
  task automatic set_in(input in_t s);
    logic sq;
    p_i = s.p; regwrite_i = s.rw; regwriteui_i = s.ui; sr_i = s.sr; dm_re_i = s.re;
    cmpsel_i = s.cmp; loadtype_i = s.lt; regfile_addr_i = s.addr; branchen_i = s.br;
    branchtype_i = s.bt; branchtarget_i = s.tgt; rst = s.rst_n;
    #1;
    chk("wb_en", 64'(wb_en_o), 64'(exp_en[cyc]));
    if (exp_en[cyc]) begin
      chk("wb_addr", 64'(wb_addr_o), 64'(exp_addr[cyc]));
      chk("wb_data", 64'(wb_data_o), 64'(exp_data[cyc]));
    end
    if (exp_zero[cyc]) begin
      chk("reset wb_addr", 64'(wb_addr_o), 64'(0));
      chk("reset wb_data", 64'(wb_data_o), 64'(0));
    end
    chk("branch_taken", 64'(branch_taken_o), 64'(bt_exp[cyc]));
    chk("branch_target", 64'(branch_target_o), 64'(tgt_exp[cyc]));
    sq = (cyc <= shadow_end);
    chk("dm_re", 64'(dm_re_o), 64'(s.re & ~sq));
    chk("dm_addr", 64'(dm_addr_o), 64'(s.p[11:2]));
  endtask

  // Reference model update for this cycle's instruction, then advance one cycle.
  task automatic commit(input in_t s);
    int c;
    logic sq, zero, neg, cond, taken, wen, ld;
    logic [31:0] data;
    c = cyc;
    sq = (c <= shadow_end);
    if (!s.rst_n) begin
      for (int k = 1; k <= 3; k++) exp_en[c+k] = 1'b0;
      exp_zero[c+1] = 1'b1;
      bt_exp[c+1] = 1'b0;
      cur_tgt = '0;
      tgt_exp[c+1] = '0;
      shadow_end = -1;
    end else begin
      zero = (s.p[31:0] == 32'd0);
      neg  = s.cmp ? ~s.p[32] : s.p[36];
      case (s.bt)
        3'd0: cond = zero;
        3'd1: cond = ~zero;
        3'd2: cond = neg;
        3'd3: cond = ~neg;
        3'd4: cond = 1'b1;
        default: cond = 1'b0;
      endcase
      taken = s.br & ~sq & cond;
      bt_exp[c+1] = taken;
      if (taken) begin
        cur_tgt = s.tgt;
        shadow_end = c + BS;
      end
      tgt_exp[c+1] = cur_tgt;
      wen = s.rw & ~sq;
      ld  = s.re & ~sq;
      if (ld)        data = ld_model(mem[s.p[11:2]], int'(s.p[1:0]), s.lt);
      else if (s.ui) data = {s.p[15:0], 16'h0000};
      else if (s.sr) data = {31'b0, neg};
      else           data = s.p[31:0];
      exp_en[c+3]   = wen;
      exp_addr[c+3] = s.addr;
      exp_data[c+3] = data;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic step(input in_t s);
    set_in(s);
    commit(s);
  endtask

  vec_t tbl [11];
  in_t  bub, s, rs;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[4] = 32'h8877_6655;
    for (int i = 0; i < N; i++) begin
      exp_en[i] = 1'b0; exp_zero[i] = 1'b0; exp_addr[i] = '0; exp_data[i] = '0;
      bt_exp[i] = 1'b0; tgt_exp[i] = '0;
    end
    exp_zero[0] = 1'b1;

    bub = mk(37'h0, 0, 0, 0, 0, 0, 3'd0, 5'd0);
    p_i = '0; regwrite_i = 0; regwriteui_i = 0; sr_i = 0; dm_re_i = 0; cmpsel_i = 0;
    loadtype_i = '0; regfile_addr_i = '0; branchen_i = 0; branchtype_i = '0;
    branchtarget_i = '0; rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    //            p              rw ui sr re cmp lt    addr         expected
    tbl[0].in  = mk(37'h10,        1, 0, 0, 1, 0, 3'd0, 5'd5);  tbl[0].exp  = 32'h8877_6655;
    tbl[1].in  = mk(37'h13,        1, 0, 0, 1, 0, 3'd3, 5'd6);  tbl[1].exp  = 32'hFFFF_FF88;
    tbl[2].in  = mk(37'h13,        1, 0, 0, 1, 0, 3'd4, 5'd7);  tbl[2].exp  = 32'h0000_0088;
    tbl[3].in  = mk(37'h13,        1, 0, 0, 1, 0, 3'd1, 5'd8);  tbl[3].exp  = 32'hFFFF_8877;
    tbl[4].in  = mk(37'h10,        1, 0, 0, 1, 0, 3'd2, 5'd9);  tbl[4].exp  = 32'h0000_6655;
    tbl[5].in  = mk(37'h10_0000_0000, 1, 0, 1, 0, 0, 3'd0, 5'd10); tbl[5].exp = 32'h1;
    tbl[6].in  = mk(37'h01_0000_0000, 1, 0, 1, 0, 1, 3'd0, 5'd11); tbl[6].exp = 32'h0;
    tbl[7].in  = mk(37'h0_ABCD,    1, 1, 0, 0, 0, 3'd0, 5'd12); tbl[7].exp  = 32'hABCD_0000;
    tbl[8].in  = mk(37'h1_2345_6789, 1, 0, 0, 0, 0, 3'd0, 5'd13); tbl[8].exp = 32'h2345_6789;
    tbl[9].in  = mk(37'h12,        1, 0, 0, 1, 0, 3'd7, 5'd14); tbl[9].exp  = 32'h8877_6655;
    tbl[10].in = mk(37'h11,        1, 1, 0, 1, 0, 3'd4, 5'd15); tbl[10].exp = 32'h0000_0066;

    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].in);
      if (i == 0) begin
        chk("word load dm_re_o", 64'(dm_re_o), 64'(1));
        chk("word load dm_addr_o", 64'(dm_addr_o), 64'(4));
      end
      commit(tbl[i].in);
      step(bub);
      step(bub);
      set_in(bub);
      chk($sformatf("vec%0d wb_en", i), 64'(wb_en_o), 64'(1));
      chk($sformatf("vec%0d wb_addr", i), 64'(wb_addr_o), 64'(tbl[i].in.addr));
      chk($sformatf("vec%0d wb_data", i), 64'(wb_data_o), 64'(tbl[i].exp));
      commit(bub);
    end

    // Taken BEQ followed by three writes; only the third survives.
    step(mkbr(37'h1_0000_0000, 3'd0, 16'h0040));
    s = mk(37'h10, 1, 0, 0, 1, 0, 3'd0, 5'd1);
    set_in(s);
    chk("beq taken", 64'(branch_taken_o), 64'(1));
    chk("beq target", 64'(branch_target_o), 64'(16'h0040));
    chk("shadow load dm_re 1", 64'(dm_re_o), 64'(0));
    commit(s);
    s = mk(37'h20, 1, 0, 0, 1, 0, 3'd0, 5'd2);
    set_in(s);
    chk("beq pulse one cycle", 64'(branch_taken_o), 64'(0));
    chk("shadow load dm_re 2", 64'(dm_re_o), 64'(0));
    commit(s);
    step(mk(37'h33, 1, 0, 0, 0, 0, 3'd0, 5'd3));
    set_in(bub); chk("shadow addr1 wb_en", 64'(wb_en_o), 64'(0)); commit(bub);
    set_in(bub); chk("shadow addr2 wb_en", 64'(wb_en_o), 64'(0)); commit(bub);
    set_in(bub);
    chk("post-shadow wb_en", 64'(wb_en_o), 64'(1));
    chk("post-shadow wb_addr", 64'(wb_addr_o), 64'(3));
    chk("post-shadow wb_data", 64'(wb_data_o), 64'(32'h33));
    commit(bub);
    step(bub);

    // BNE with zero=0 inside a taken branch's shadow is ignored.
    step(mkbr(37'h0, 3'd4, 16'h0080));
    step(mkbr(37'h5, 3'd1, 16'h1234));
    set_in(bub);
    chk("shadow bne taken", 64'(branch_taken_o), 64'(0));
    chk("shadow bne target", 64'(branch_target_o), 64'(16'h0080));
    commit(bub);
    step(bub);
    step(bub);

    // Reset while a load is in flight.
    step(mk(37'h10, 1, 0, 0, 1, 0, 3'd0, 5'd7));
    rs = bub; rs.rst_n = 1'b0;
    step(rs);
    set_in(bub);
    chk("reset wb_en", 64'(wb_en_o), 64'(0));
    chk("reset wb_data_o", 64'(wb_data_o), 64'(0));
    chk("reset branch_target", 64'(branch_target_o), 64'(0));
    chk("reset branch_taken", 64'(branch_taken_o), 64'(0));
    commit(bub);
    set_in(bub); chk("reset +2 wb_en", 64'(wb_en_o), 64'(0)); commit(bub);
    set_in(bub); chk("reset +3 wb_en", 64'(wb_en_o), 64'(0)); commit(bub);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      s.p   = {5'($urandom), 32'($urandom)};
      if ($urandom_range(3) == 0) s.p[31:0] = 32'h0;
      s.rw  = 1'($urandom_range(1));
      s.ui  = ($urandom_range(3) == 0);
      s.sr  = ($urandom_range(3) == 0);
      s.re  = 1'($urandom_range(1));
      s.cmp = 1'($urandom_range(1));
      s.lt  = 3'($urandom_range(7));
      s.addr = 5'($urandom_range(31));
      s.br  = ($urandom_range(5) == 0);
      s.bt  = 3'($urandom_range(7));
      s.tgt = 16'($urandom);
      s.rst_n = ($urandom_range(149) != 0);
      step(s);
    end
    step(bub);
    step(bub);
    step(bub);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Stage directly downstream of the execute stage. Consumes the ALU result and the propagated control signals.
- Issues data-memory reads and aligns and extends the load data.
- Forms set-on-compare and upper-immediate results, then drives the register-file write port.
- Resolves branches and redirects fetch, squashing the branch shadow.
- Fixed in-order latency; no stalls.

Parameters:
DM_ADDR_WIDTH, 10, data-memory word-address width (must be <= 30)
DM_LATENCY, 2, cycles from dm_re_o to valid dm_rdata_i (>= 1)
BRANCH_SHADOW, 2, number of inputs squashed after a taken branch (0 disables squashing)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-low
p_i  in  37  execute result {P[47], P[35:0]}
regwrite_i  in  1  write result to register file
regwriteui_i  in  1  upper-immediate write
sr_i  in  1  set-on-compare write
regfile_addr_i  in  REG_ADDR_WIDTH  destination register
dm_re_i  in  1  load
cmpsel_i  in  1  compare flag source: 0 = signed, 1 = unsigned
loadtype_i  in  3  load size/sign
branchen_i  in  1  branch instruction
branchtype_i  in  3  branch condition
branchtarget_i  in  16  branch target PC
dm_rdata_i  in  32  data-memory read word
dm_re_o  out  1  data-memory read enable
dm_addr_o  out  DM_ADDR_WIDTH  data-memory word address
wb_en_o  out  1  register-file write enable
wb_addr_o  out  REG_ADDR_WIDTH  register-file write address
wb_data_o  out  DATA_WIDTH  register-file write data
branch_taken_o  out  1  one-cycle redirect pulse
branch_target_o  out  16  redirect PC

Behaviour:
Reset
- rst==0 at a clock edge clears every register: all outputs are 0, the pipeline is cleared of valid entries, and the squash counter is 0.
- Reset mid-operation drops in-flight loads; no wb_en_o pulse after reset for any pre-reset input.

Inputs and squashing
- Each cycle's inputs form one instruction. There is no valid bit; an instruction with regwrite_i=0, dm_re_i=0, branchen_i=0 is a bubble.
- squash = (squash counter != 0). A squashed instruction has regwrite, dm_re and branchen forced to 0 before any use.

Flags (combinational on p_i)
- zero = (p_i[31:0]==0)
- neg = cmpsel_i ? ~p_i[32] : p_i[36]

Data-memory read (combinational from inputs)
- dm_re_o = dm_re_i & ~squash
- dm_addr_o = p_i[DM_ADDR_WIDTH+1:2]
- Byte offset p_i[1:0] is carried with the instruction.

Pipeline
- Shift pipeline DM_LATENCY deep, followed by one output register. Total input-to-wb latency = DM_LATENCY+1 (default 3) for every instruction, in order.
- The last pipe entry samples dm_rdata_i in the same cycle it is loaded into the output register.

Writeback data priority
- load: loadtype 000 = word; 001 = sign-extended halfword at offset[1]; 010 = zero-extended halfword; 011 = sign-extended byte at offset[1:0]; 100 = zero-extended byte; 101-111 = word. Little-endian lanes.
- regwriteui: {p_i[15:0], 16'h0000}
- sr: {31'b0, neg}
- otherwise: p_i[31:0]

Writeback control
- wb_en_o = registered regwrite after squash.
- wb_addr_o is registered alongside wb_en_o.

Branch (latency 1)
- Conditions: 000 = zero; 001 = ~zero; 010 = neg; 011 = ~neg; 100 = always; 101-111 = never.
- taken = branchen & ~squash & cond.
- branch_taken_o is registered taken, high for exactly one cycle.
- branch_target_o is registered branchtarget_i when taken, otherwise held.

Squash counter
- On taken, the counter loads BRANCH_SHADOW; otherwise it decrements while nonzero.
- Result: inputs at cycles T+1 .. T+BRANCH_SHADOW are squashed.
- A branch inside the shadow is itself squashed and does not reload the counter.
- A load plus regwrite instruction that is also a branch is legal; both effects apply.

Test Plan:
- Word load: p_i=0x0000_0010, dm_re=1, regwrite=1, addr=5, loadtype=000; memory word 4 = 0x8877_6655.
  - Required: dm_re_o=1 and dm_addr_o=4 in the same cycle.
  - Required: 3 cycles later wb_en_o=1, wb_addr_o=5, wb_data_o=0x8877_6655.
- Byte loads from the same word, p_i=0x13:
  - loadtype=011 -> wb_data_o=0xFFFF_FF88.
  - loadtype=100 -> wb_data_o=0x0000_0088.
  - loadtype=001 -> wb_data_o=0xFFFF_8877.
- Set-on-compare:
  - sr=1, cmpsel=0, p_i[36]=1 -> wb_data_o=1.
  - sr=1, cmpsel=1, p_i[32]=1 -> wb_data_o=0.
  - regwriteui=1, p_i[15:0]=0xABCD -> wb_data_o=0xABCD_0000.
- Branch shadow: BEQ with p_i[31:0]=0, target 0x0040, followed by 3 back-to-back writes (addrs 1, 2, 3).
  - Required: branch_taken_o=1 for one cycle with branch_target_o=0x0040.
  - Required: only addr 3 is written; no dm_re_o for a load in the shadow.
- BNE in the shadow of a taken branch, with zero=0 -> no second branch_taken_o pulse.
- Reset mid-operation: load issued, then rst=0 for one cycle -> all outputs 0, and wb_en_o stays 0 for the following 3 cycles.
